sha256_msg_buffer: RTL and testbench
====================================

Name: sha256_msg_buffer

Overview:
- Upstream feeder for sha256_update.
- Accepts 32-bit big-endian message words over a valid/ready stream and collects them into a 16-word block store.
- Pulses `update` to the hash core once a block is ready, then serves the core's word reads with one-cycle registered latency until `done` returns.
- Tracks block count and message end, and signals when the final intermediate hash has completed.

Parameters:
- DATA_W, 32, message word width.
- NUM_WORDS, 16, words per block; the address width is log2(NUM_WORDS) = 4.
- BLK_W, 55, width of the block counter (matches the hash core's `cur_block`).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- s_word  in  DATA_W  incoming message word.
- s_valid  in  1  s_word is valid.
- s_last  in  1  qualifies s_word as the final word of the message.
- s_ready  out  1  buffer accepts a word this cycle.
- rd_addr  in  4  word read address from the core (block_offset).
- rd_data  out  DATA_W  registered read data, one cycle after rd_addr.
- update  out  1  one-cycle start pulse to the hash core.
- upd_done  in  1  hash core `done` pulse.
- block_count  out  BLK_W  blocks issued for the current message.
- busy  out  1  high in every state except FILL.
- msg_done  out  1  one-cycle pulse: the last block of the message has been hashed.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = FILL, wr_ptr = 0, valid_mask = 0, last_seen = 0.
  - rd_data = 0, block_count = 0.
  - update = 0, msg_done = 0, busy = 0, s_ready = 0.
  - Store contents are don't-care because valid_mask masks them.
- Handshake: a word transfers when s_valid && s_ready on a rising edge. s_ready is combinational from state (1 only in FILL). Words are written to mem[wr_ptr], valid_mask[wr_ptr] is set, and wr_ptr increments.
- Read path: rd_data <= valid_mask[rd_addr] ? mem[rd_addr] : 0, registered every cycle in every state. Words never written read back as zero, which the padder requires for partial blocks.
- State FILL:
  - Accept words.
  - Go to ISSUE on an accepted word when wr_ptr == 15 or s_last == 1.
  - When the transfer carries s_last, set last_seen.
- State ISSUE:
  - update = 1 for exactly one cycle.
  - block_count increments in this cycle.
  - Next state is HASH.
- State HASH:
  - s_ready = 0; contents are held stable.
  - On upd_done = 1: if last_seen, go to FINISH; otherwise go to FILL with wr_ptr = 0 and valid_mask = 0.
  - The core's internal overflow-pad pass reads the same store. It is handled inside the core, so the buffer simply keeps waiting for the single done.
- State FINISH:
  - msg_done = 1 for one cycle.
  - Clear last_seen, wr_ptr, valid_mask and block_count.
  - Next state is FILL.
- Boundary conditions:
  - upd_done outside HASH is ignored.
  - s_last on word 16 (wr_ptr == 15) is one transition to ISSUE, with last_seen set.
  - s_valid with s_last outside FILL is not accepted, because s_ready = 0.
  - block_count wraps modulo 2^BLK_W.
  - Empty messages (zero words) are not supported: s_last always qualifies a real word.
  - Reset asserted in any state (including HASH or ISSUE) aborts immediately. No update or msg_done pulse is emitted after reset asserts.
- Latency:
  - Last accepted word to update: 1 cycle.
  - upd_done to s_ready re-asserting: 1 cycle.
  - upd_done to msg_done: 1 cycle.

Test Plan:
- Full block, not last: stream words 0x00000000..0x0000000F with s_last = 0 on the last one. Expect update to pulse 1 cycle after the 16th accept, block_count = 1, and s_ready = 0 until upd_done.
- Read latency: in HASH, drive rd_addr = 3, then 7. Expect rd_data = 0x00000003 and then 0x00000007, each exactly one cycle after its address.
- Partial last block: send "abc" as the single word 0x61626380 with s_last = 1. Expect update 1 cycle later, rd_addr = 1..15 returning 0, and msg_done pulsing 1 cycle after upd_done, with block_count back to 0.
- Multi-block: 20 words, s_last on the 20th.
  - First upd_done: FILL resumes, and words 16..19 land at addresses 0..3.
  - Addresses 4..15 read 0.
  - block_count = 2 at the second update.
  - A single msg_done pulse follows the second upd_done.
- Spurious done: pulse upd_done while in FILL with wr_ptr = 5. Expect no state change, no msg_done, and wr_ptr still 5.
- Reset mid-hash: assert reset asynchronously in HASH. Expect s_ready = 0 and busy = 0 immediately, block_count = 0, rd_data = 0, and after release FILL with all reads returning 0.

Source files
------------

// File: rtl/sha256_msg_buffer.sv
// Message-word collector feeding sha256_update: fills a 16-word block store,
// issues update, serves the core's registered word reads and tracks block count and message end.
module sha256_msg_buffer #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 16,
  parameter int BLK_W     = 55,
  localparam int AW       = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_word,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              update,
  input  logic              upd_done,
  output logic [BLK_W-1:0]  block_count,
  output logic              busy,
  output logic              msg_done
);

  typedef enum logic [1:0] {FILL, ISSUE, HASH, FINISH} state_t;

  state_t                state_q;
  logic [DATA_W-1:0]     mem_q [NUM_WORDS];
  logic [NUM_WORDS-1:0]  valid_mask_q;
  logic [AW-1:0]         wr_ptr_q;
  logic                  last_seen_q;
  logic                  update_q;
  logic                  msg_done_q;
  logic [BLK_W-1:0]      block_count_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  accept;

  // Gated by reset so the stream stalls the instant reset asserts.
  assign s_ready     = (state_q == FILL) && !reset;
  assign busy        = (state_q != FILL);
  assign accept      = s_valid && s_ready;
  assign update      = update_q;
  assign msg_done    = msg_done_q;
  assign block_count = block_count_q;
  assign rd_data     = rd_data_q;

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= s_word;
  end

  // Unwritten slots read as zero so partial blocks arrive pre-zeroed for padding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= valid_mask_q[rd_addr] ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      valid_mask_q  <= '0;
      last_seen_q   <= 1'b0;
      update_q      <= 1'b0;
      msg_done_q    <= 1'b0;
      block_count_q <= '0;
    end else begin
      update_q   <= 1'b0;
      msg_done_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            valid_mask_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q               <= wr_ptr_q + 1'b1;
            if (s_last) last_seen_q <= 1'b1;
            if (wr_ptr_q == AW'(NUM_WORDS - 1) || s_last) begin
              state_q       <= ISSUE;
              update_q      <= 1'b1;
              block_count_q <= block_count_q + 1'b1;
            end
          end
        end
        ISSUE: state_q <= HASH;
        HASH: begin
          if (upd_done) begin
            if (last_seen_q) begin
              state_q    <= FINISH;
              msg_done_q <= 1'b1;
            end else begin
              state_q      <= FILL;
              wr_ptr_q     <= '0;
              valid_mask_q <= '0;
            end
          end
        end
        FINISH: begin
          state_q       <= FILL;
          last_seen_q   <= 1'b0;
          wr_ptr_q      <= '0;
          valid_mask_q  <= '0;
          block_count_q <= '0;
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_buffer.sv
// Bench for sha256_msg_buffer: directed scenarios pinned with literal values, then
// randomized traffic compared every cycle against a block-level reference model.
module tb_sha256_msg_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_word;
  logic        s_valid, s_last, s_ready;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        update, upd_done, busy, msg_done;
  logic [54:0] block_count;

  int n_cmp = 0;
  int n_err = 0;

  sha256_msg_buffer dut (
    .clk(clk), .reset(reset), .s_word(s_word), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .rd_addr(rd_addr), .rd_data(rd_data), .update(update),
    .upd_done(upd_done), .block_count(block_count), .busy(busy), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 collecting, 1 issuing, 2 core hashing, 3 message finished.
  int              m_phase;
  logic [31:0]     m_mem [16];
  bit   [15:0]     m_val;
  int              m_n;
  bit              m_last;
  longint unsigned m_blocks;
  logic [31:0]     m_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_val = '0; m_last = 0; m_blocks = 0; m_rd = '0;
  endtask

  task automatic check_model();
    chk("s_ready",     64'(s_ready),     64'(m_phase == 0));
    chk("busy",        64'(busy),        64'(m_phase != 0));
    chk("update",      64'(update),      64'(m_phase == 1));
    chk("msg_done",    64'(msg_done),    64'(m_phase == 3));
    chk("block_count", 64'(block_count), m_blocks);
    chk("rd_data",     64'(rd_data),     64'(m_rd));
  endtask

  // Applies one cycle of inputs, advances the model across the edge, then compares.
  task automatic step(input bit v, input logic [31:0] w, input bit l, input logic [3:0] a, input bit d);
    logic [31:0] rd_next;
    s_valid = v; s_word = w; s_last = l; rd_addr = a; upd_done = d;
    rd_next = m_val[a] ? m_mem[a] : 32'h0;
    case (m_phase)
      0: if (v) begin
        m_mem[m_n] = w;
        m_val[m_n] = 1'b1;
        if (l) m_last = 1;
        if (m_n == 15 || l) begin
          m_phase  = 1;
          m_blocks = (m_blocks + 1) & ((64'd1 << 55) - 1);
        end
        m_n = (m_n + 1) % 16;
      end
      1: m_phase = 2;
      2: if (d) begin
        if (m_last) m_phase = 3;
        else begin m_phase = 0; m_n = 0; m_val = '0; end
      end
      default: begin
        m_phase = 0; m_last = 0; m_n = 0; m_val = '0; m_blocks = 0;
      end
    endcase
    m_rd = rd_next;
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int budget;
    reset = 1'b1; s_valid = 0; s_word = '0; s_last = 0; rd_addr = '0; upd_done = 0;
    model_reset();
    #3;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_update", 64'(update), 64'd0);
    chk("rst_msg_done", 64'(msg_done), 64'd0);
    chk("rst_block_count", 64'(block_count), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Full 16-word block, not last
    for (int i = 0; i < 16; i++) step(1, 32'(i), 0, 4'd0, 0);
    chk("full_update", 64'(update), 64'd1);
    chk("full_bc", 64'(block_count), 64'd1);
    step(0, 32'h0, 0, 4'd3, 0);
    chk("rd_addr3", 64'(rd_data), 64'h3);
    step(1, 32'hdead_beef, 1, 4'd7, 0);
    chk("rd_addr7", 64'(rd_data), 64'h7);
    chk("hash_no_ready", 64'(s_ready), 64'd0);
    step(1, 32'hdead_beef, 1, 4'd7, 0);
    step(0, 32'h0, 0, 4'd0, 1);
    chk("resume_ready", 64'(s_ready), 64'd1);

    // Single-word last block continuing the same message
    step(1, 32'h6162_6380, 1, 4'd0, 0);
    chk("abc_update", 64'(update), 64'd1);
    chk("abc_bc", 64'(block_count), 64'd2);
    step(0, 32'h0, 0, 4'd0, 0);
    chk("abc_word0", 64'(rd_data), 64'h6162_6380);
    for (int a = 1; a < 16; a++) begin
      step(0, 32'h0, 0, 4'(a), 0);
      chk("abc_zero", 64'(rd_data), 64'd0);
    end
    step(0, 32'h0, 0, 4'd0, 1);
    chk("abc_msg_done", 64'(msg_done), 64'd1);
    step(0, 32'h0, 0, 4'd0, 0);
    chk("abc_msg_done_end", 64'(msg_done), 64'd0);
    chk("abc_bc_clear", 64'(block_count), 64'd0);

    // 20-word message across two blocks
    for (int i = 0; i < 16; i++) step(1, 32'(100 + i), 0, 4'd0, 0);
    chk("mb_bc1", 64'(block_count), 64'd1);
    step(0, 32'h0, 0, 4'd0, 0);
    step(0, 32'h0, 0, 4'd0, 1);
    for (int i = 16; i < 20; i++) step(1, 32'(100 + i), i == 19, 4'd0, 0);
    chk("mb_update2", 64'(update), 64'd1);
    chk("mb_bc2", 64'(block_count), 64'd2);
    for (int a = 0; a < 16; a++) begin
      step(0, 32'h0, 0, 4'(a), 0);
      chk("mb_read", 64'(rd_data), (a < 4) ? 64'(116 + a) : 64'd0);
    end
    step(0, 32'h0, 0, 4'd0, 1);
    chk("mb_msg_done", 64'(msg_done), 64'd1);
    step(0, 32'h0, 0, 4'd0, 0);
    chk("mb_single_pulse", 64'(msg_done), 64'd0);

    // Spurious done with five words buffered
    for (int i = 0; i < 5; i++) step(1, 32'(200 + i), 0, 4'd0, 0);
    step(0, 32'h0, 0, 4'd0, 1);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_msg_done", 64'(msg_done), 64'd0);
    step(1, 32'h0000_0555, 0, 4'd5, 0);
    step(0, 32'h0, 0, 4'd5, 0);
    chk("spur_wr_ptr5", 64'(rd_data), 64'h555);

    // Randomized traffic
    for (int k = 0; k < 3000; k++)
      step(($urandom % 10) < 7, $urandom, ($urandom % 12) == 0, 4'($urandom), ($urandom % 6) == 0);

    // Reset while the core is hashing
    budget = 0;
    while (m_phase != 2 && budget < 200) begin
      step(1, $urandom, 0, 4'($urandom), 0);
      budget++;
    end
    chk("reach_hash_budget", 64'(m_phase == 2), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_bc", 64'(block_count), 64'd0);
    chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
    chk("mid_rst_update", 64'(update), 64'd0);
    chk("mid_rst_msg_done", 64'(msg_done), 64'd0);
    s_valid = 0; upd_done = 0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      step(0, 32'h0, 0, 4'(a), ($urandom % 2) == 0);
      chk("post_rst_zero", 64'(rd_data), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
